// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer (main/side + ped crossing), stepped by 1 Hz divider ticks.
// Lamps registered with the state: change on the clk edge after the qualifying tick; no backpressure.
module traffic_light_controller #(
  parameter logic [7:0] MAIN_MIN   = 8'd10,
  parameter logic [7:0] SIDE_GREEN = 8'd6,
  parameter logic [7:0] YELLOW     = 8'd3,
  parameter logic [7:0] ALL_RED    = 8'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_1hz,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       clk_1hz_d;
  logic       tick;
  logic [7:0] timer;
  logic       side_pend;
  logic       ped_pend;
  logic       ped_serv;
  logic       changing;
  logic       enter_sg;
  logic       leave_sg;
  logic       main_min_done;

  assign tick          = clk_1hz & ~clk_1hz_d;
  assign main_min_done = (timer >= (MAIN_MIN - 8'd1));

  function automatic logic elapsed(input logic tk, input logic [7:0] t, input logic [7:0] d);
    return tk && (t == (d - 8'd1));
  endfunction

  // {main, side} lamps, each {red, yellow, green}; unknown codes show all-red
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      MG:      return 6'b001_100;
      MY:      return 6'b010_100;
      SG:      return 6'b100_001;
      SY:      return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      MG:  if (tick && main_min_done && (side_pend || ped_pend)) state_nxt = MY;
      MY:  if (elapsed(tick, timer, YELLOW))     state_nxt = AR1;
      AR1: if (elapsed(tick, timer, ALL_RED))    state_nxt = SG;
      SG:  if (elapsed(tick, timer, SIDE_GREEN)) state_nxt = SY;
      SY:  if (elapsed(tick, timer, YELLOW))     state_nxt = AR2;
      AR2: if (elapsed(tick, timer, ALL_RED))    state_nxt = MG;
      default:                                   state_nxt = AR2;
    endcase
  end

  assign changing = (state_nxt != state);
  assign enter_sg = (state_nxt == SG) && (state != SG);
  assign leave_sg = (state == SG) && (state_nxt != SG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= AR2;
      timer      <= 8'd0;
      clk_1hz_d  <= 1'b1;
      side_pend  <= 1'b0;
      ped_pend   <= 1'b0;
      ped_serv   <= 1'b0;
      main_light <= 3'b100;
      side_light <= 3'b100;
      ped_walk   <= 1'b0;
    end else begin
      clk_1hz_d <= clk_1hz;
      state     <= state_nxt;
      {main_light, side_light} <= lamps(state_nxt);

      // MG parks its timer at MAIN_MIN-1 so a late request leaves on the very next tick
      if (changing)
        timer <= 8'd0;
      else if (tick && !((state == MG) && main_min_done))
        timer <= timer + 8'd1;

      // a request present on the SG-entry clk survives the clear and is served next cycle
      side_pend <= side_req | (side_pend & ~enter_sg);
      ped_pend  <= ped_req  | (ped_pend  & ~enter_sg);

      if (enter_sg)
        ped_serv <= ped_pend;
      else if (leave_sg)
        ped_serv <= 1'b0;

      ped_walk <= (state_nxt == SG) && (enter_sg ? ped_pend : ped_serv);
    end
  end

  assign phase = state;

`ifndef SYNTHESIS
  a_lamps_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot(main_light) && $onehot(side_light));
  a_no_conflict: assert property (@(posedge clk) disable iff (!reset_n)
    main_light[2] || side_light[2]);
  a_walk_side_green: assert property (@(posedge clk) disable iff (!reset_n)
    ped_walk |-> (side_light == 3'b001));
`endif

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: phase-table model compared every cycle plus literal checkpoints.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_1hz = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  traffic_light_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_1hz    (clk_1hz),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Phase order MG, MY, AR1, SG, SY, AR2 with durations in ticks and lamps per phase
  int         dur      [6] = '{10, 3, 1, 6, 3, 1};
  logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_ph   = 5;
  int m_cnt  = 0;
  bit m_sp   = 1'b0;
  bit m_pp   = 1'b0;
  bit m_serv = 1'b0;
  bit m_prev = 1'b1;
  bit m_tk;
  bit m_adv;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 5; m_cnt = 0; m_sp = 1'b0; m_pp = 1'b0; m_serv = 1'b0; m_prev = 1'b1;
    end else begin
      m_tk   = clk_1hz && !m_prev;
      m_prev = clk_1hz;
      m_adv  = 1'b0;
      if (m_tk) begin
        m_cnt++;
        if (m_ph == 0) m_adv = (m_cnt >= dur[0]) && (m_sp || m_pp);
        else           m_adv = (m_cnt == dur[m_ph]);
      end
      if (m_adv) begin
        if (m_ph == 3) m_serv = 1'b0;
        m_ph  = (m_ph + 1) % 6;
        m_cnt = 0;
        if (m_ph == 3) begin
          m_serv = m_pp; m_sp = 1'b0; m_pp = 1'b0;
        end
      end
      if (side_req) m_sp = 1'b1;
      if (ped_req)  m_pp = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_phase", {5'd0, phase}, 8'(m_ph));
    chk("model_main", {5'd0, main_light}, {5'd0, main_tab[m_ph]});
    chk("model_side", {5'd0, side_light}, {5'd0, side_tab[m_ph]});
    chk("model_walk", {7'd0, ped_walk}, {7'd0, (m_ph == 3) && m_serv});
    chk("safety_red", {7'd0, main_light[2] | side_light[2]}, 8'd1);
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) clk_1hz = 1'b1;
      repeat (3) @(negedge clk);
      clk_1hz = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pulse_side();
    @(negedge clk) side_req = 1'b1;
    @(negedge clk) side_req = 1'b0;
  endtask

  task automatic pulse_ped();
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
  endtask

  initial begin
    // Reset and idle: AR2 for one tick, then MG held indefinitely
    do_reset();
    chk("rst_phase", {5'd0, phase}, 8'd5);
    chk("rst_main", {5'd0, main_light}, 8'b100);
    chk("rst_side", {5'd0, side_light}, 8'b100);
    chk("rst_walk", {7'd0, ped_walk}, 8'd0);
    tick_n(1);
    chk("idle_enter_mg", {5'd0, phase}, 8'd0);
    tick_n(30);
    chk("idle_hold_mg", {5'd0, phase}, 8'd0);
    chk("idle_main_green", {5'd0, main_light}, 8'b001);
    chk("idle_side_red", {5'd0, side_light}, 8'b100);

    // Side request 2 ticks into MG: MY at MG tick 10, then 3/1/6/3/1
    do_reset();
    tick_n(1);
    tick_n(2);
    pulse_side();
    tick_n(7);
    chk("side_mg_tick9", {5'd0, phase}, 8'd0);
    tick_n(1);
    chk("side_my", {5'd0, phase}, 8'd1);
    tick_n(2);
    chk("side_my_hold", {5'd0, phase}, 8'd1);
    tick_n(1);
    chk("side_ar1", {5'd0, phase}, 8'd2);
    tick_n(1);
    chk("side_sg", {5'd0, phase}, 8'd3);
    chk("side_sg_nowalk", {7'd0, ped_walk}, 8'd0);
    tick_n(5);
    chk("side_sg_hold", {5'd0, phase}, 8'd3);
    tick_n(1);
    chk("side_sy", {5'd0, side_light}, 8'b010);
    tick_n(3);
    chk("side_ar2", {5'd0, phase}, 8'd5);
    tick_n(1);
    chk("side_back_mg", {5'd0, phase}, 8'd0);

    // Pedestrian request during MY: walk for exactly the SG ticks
    pulse_side();
    tick_n(10);
    chk("ped_my", {5'd0, phase}, 8'd1);
    pulse_ped();
    tick_n(3);
    chk("ped_ar1", {5'd0, phase}, 8'd2);
    tick_n(1);
    chk("ped_walk_on", {7'd0, ped_walk}, 8'd1);
    tick_n(5);
    chk("ped_walk_last", {7'd0, ped_walk}, 8'd1);
    tick_n(1);
    chk("ped_walk_off", {7'd0, ped_walk}, 8'd0);
    tick_n(4);
    chk("ped_back_mg", {5'd0, phase}, 8'd0);
    tick_n(15);
    chk("ped_pend_cleared", {5'd0, phase}, 8'd0);

    // Side request held: 24-tick repeating cycle
    @(negedge clk) side_req = 1'b1;
    tick_n(1);
    chk("held_my", {5'd0, phase}, 8'd1);
    tick_n(23);
    chk("held_mg_tick9", {5'd0, phase}, 8'd0);
    tick_n(1);
    chk("held_my_again", {5'd0, phase}, 8'd1);
    side_req = 1'b0;

    // clk_1hz already high at reset release: no tick until next rising edge
    @(negedge clk) clk_1hz = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    clk_1hz = 1'b0;
    repeat (4) @(negedge clk);
    chk("hi_rel_no_tick", {5'd0, phase}, 8'd5);
    tick_n(1);
    chk("hi_rel_mg", {5'd0, phase}, 8'd0);

    // Asynchronous reset mid-SG while walking
    pulse_ped();
    tick_n(9);
    chk("async_mg", {5'd0, phase}, 8'd0);
    tick_n(1);
    tick_n(3);
    tick_n(1);
    chk("async_sg", {5'd0, phase}, 8'd3);
    tick_n(2);
    chk("async_walk_before", {7'd0, ped_walk}, 8'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_phase", {5'd0, phase}, 8'd5);
    chk("async_main", {5'd0, main_light}, 8'b100);
    chk("async_side", {5'd0, side_light}, 8'b100);
    chk("async_walk", {7'd0, ped_walk}, 8'd0);
    @(negedge clk) reset_n = 1'b1;
    tick_n(1);
    chk("async_restart_mg", {5'd0, phase}, 8'd0);
    tick_n(12);
    chk("async_pend_lost", {5'd0, phase}, 8'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
